spi_master_ctrl: RTL
====================

// Module: spi_master_ctrl
// PURPOSE
//  Host-side SPI master for the RAM link; drives the far end of the existing SPI slave.
//  Takes 10-bit frames {cmd[1:0], payload[7:0]} from a host (test driver or CPU stub) and shifts them out on MOSI.
//  For read-data frames it also collects the 8-bit RAM word the slave returns on MISO.
//  Shares clk with the slave; no separate SCLK. All SPI outputs are registered on posedge clk.
// PARAMETERS
//  FRAME_W  10  bits per MOSI frame (cmd[1:0] + payload)
//  DATA_W    8  bits returned on MISO for a read-data frame
//  RD_WAIT   2  idle cycles between the last MOSI bit and the first MISO sample (slave/RAM turnaround)
//  GAP       1  minimum cycles SS_n stays high between frames (>=1)
// PORTS
//  clk        in   1        system clock; shared with SPI slave
//  rst_n      in   1        asynchronous, active-low reset
//  cmd_valid  in   1        host frame valid
//  cmd_ready  out  1        master can accept a frame (IDLE only)
//  cmd_data   in   FRAME_W  frame; [9:8]=00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//  abort      in   1        terminate current frame
//  rd_valid   out  1        one-cycle pulse; rd_data valid
//  rd_data    out  DATA_W   word received on MISO
//  busy       out  1        high whenever state != IDLE
//  SS_n       out  1        slave select, active low
//  MOSI       out  1        serial data to slave, MSB first
//  MISO       in   1        serial data from slave, MSB first
// BEHAVIOUR
//  Reset (async): state=IDLE, SS_n=1, MOSI=0, rd_valid=0, rd_data=0, busy=0. cmd_ready=1 after reset.
//  Reset mid-frame: SS_n rises immediately (async); partial frame is discarded; no rd_valid.
//  FSM states: IDLE, START, SHIFT, WAIT, RECV, DONE.
//  IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_data into shift reg -> START.
//  START (1 cyc): SS_n=0, MOSI=frame[9] (command peek sampled by slave CHK_CMD) -> SHIFT.
//  SHIFT (FRAME_W cyc): SS_n=0, MOSI=frame[9],frame[8],...,frame[0], one bit per cycle.
//    After bit 0: if frame[9:8]==2'b11 -> WAIT; otherwise -> DONE.
//  WAIT (RD_WAIT cyc): SS_n=0, MOSI=0. With RD_WAIT=0, go directly to RECV.
//  RECV (DATA_W cyc): SS_n=0, MOSI=0. Sample MISO each posedge; shift in MSB first.
//    On the cycle after the 8th sample: rd_data=assembled word and rd_valid=1 for exactly 1 cycle.
//    The same transition enters DONE.
//  DONE (GAP cyc): SS_n=1, MOSI=0 -> IDLE.
//  Frame length with SS_n low: 1+FRAME_W cycles for write/rd-addr frames.
//    Read-data frame: 1+FRAME_W+RD_WAIT+DATA_W cycles.
//  Minimum accept-to-accept spacing: 1+(SS_n-low cycles)+GAP cycles.
//  cmd_ready=0 outside IDLE. A cmd_valid seen while busy is neither consumed nor queued.
//  abort: honoured in START/SHIFT/WAIT/RECV. Next cycle SS_n=1 and state=DONE; no rd_valid.
//    abort in IDLE/DONE is ignored. abort has priority over a same-cycle RECV completion.
//  Simultaneous: cmd_valid in the DONE->IDLE cycle is not accepted; it is accepted on the first IDLE cycle.
//  rd_data holds its last value until the next completed read. MISO is ignored outside RECV.
//  Counters: bit counter width $clog2(max(FRAME_W,DATA_W,RD_WAIT,GAP)+1).
//    Each phase reloads the counter; there is no wrap-around across phases.
// STRUCTURE
//  spi_pkg: state encoding localparams; CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
//  One sub-module: spi_shift_reg (parallel load, MSB-first shift-out, MSB-first shift-in, width param).
//    The master instantiates two: TX (FRAME_W) and RX (DATA_W).
//  FSM, phase counter and abort logic stay in spi_master_ctrl.
// TESTING
//  Bench pairs this block with the SPI slave + RAM model and a self-checking scoreboard.
//  T1 reset: hold rst_n=0 5 cyc -> SS_n=1, MOSI=0, rd_valid=0, busy=0, cmd_ready=1.
//  T2 write addr: cmd_data=10'h0_A5 -> SS_n low 11 cyc; MOSI seq 0,0,0,1,0,1,0,0,1,0,1; slave rx_data=10'h0A5.
//  T3 write data: 10'h1_3C after T2 -> RAM[0xA5]=0x3C. Then rd addr 10'h2_A5, then rd data 10'h3_00
//     -> SS_n low 1+10+2+8=21 cyc; rd_valid single pulse with rd_data=8'h3C.
//  T4 back-to-back: cmd_valid held high for 3 frames -> accepts spaced by exactly 13 cyc; SS_n high >=GAP between frames.
//  T5 abort: assert abort on 5th SHIFT cycle -> SS_n=1 next cycle; no rd_valid; cmd_ready=1 after GAP; next frame correct.
//  T6 reset mid-RECV: rst_n low on 3rd MISO bit -> SS_n=1 asynchronously; rd_valid never asserts;
//     rd_data=0; a post-reset read returns the correct word.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the host-side SPI master: FSM encoding, frame command codes, helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_DONE
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Width-parameterised shift register: parallel load, MSB-first shift (out at q[W-1], in at q[0]).
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        q <= '0;
    else if (load)     q <= load_data;
    else if (shift_en) q <= {q[W-2:0], shift_in};
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master for the RAM link: shifts 10-bit command frames out on MOSI and
// collects the returned RAM word on MISO for read-data frames. Shares clk with the slave.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_data,
  input  logic               abort,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int CNT_MAX = max_int(max_int(FRAME_W, DATA_W), max_int(RD_WAIT, GAP));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LD_SHIFT   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LD_RECV    = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LD_GAP     = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] LD_POST_TX = (RD_WAIT == 0) ? LD_RECV : CNT_W'(RD_WAIT - 1);
  localparam state_e           ST_POST_TX = (RD_WAIT == 0) ? ST_RECV : ST_WAIT;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rd_frame_q;
  logic                 ss_n_d, rd_valid_d;
  logic                 accept, in_frame;
  logic                 tx_load, tx_shift, rx_shift;
  logic [FRAME_W-1:0]   tx_q, tx_ld_data;
  logic [DATA_W-1:0]    rx_q;
  logic                 unused_bits;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign in_frame  = state_q inside {ST_START, ST_SHIFT, ST_WAIT, ST_RECV};

  // MOSI comes straight off the TX flop MSB; zeros shifted in behind the frame keep it low afterwards.
  assign MOSI       = tx_q[FRAME_W-1];
  assign tx_ld_data = in_frame ? '0 : cmd_data;
  assign unused_bits = ^{tx_q[FRAME_W-2:0], rx_q[DATA_W-1]};

  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk(clk), .rst_n(rst_n), .load(tx_load), .load_data(tx_ld_data),
    .shift_en(tx_shift), .shift_in(1'b0), .q(tx_q)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .load_data('0),
    .shift_en(rx_shift), .shift_in(MISO), .q(rx_q)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ss_n_d     = 1'b1;
    rd_valid_d = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    rx_shift   = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        tx_load = 1'b1;
        ss_n_d  = 1'b0;
        state_d = ST_START;
      end
      ST_START: begin
        ss_n_d  = 1'b0;
        cnt_d   = LD_SHIFT;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        ss_n_d   = 1'b0;
        tx_shift = 1'b1;
        if (cnt_q != '0)     cnt_d = cnt_q - 1'b1;
        else if (rd_frame_q) begin
          cnt_d   = LD_POST_TX;
          state_d = ST_POST_TX;
        end else begin
          ss_n_d  = 1'b1;
          cnt_d   = LD_GAP;
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        ss_n_d = 1'b0;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          cnt_d   = LD_RECV;
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        ss_n_d   = 1'b0;
        rx_shift = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          ss_n_d     = 1'b1;
          rd_valid_d = 1'b1;
          cnt_d      = LD_GAP;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over everything, including a read completing on the same edge.
    if (abort && in_frame) begin
      state_d    = ST_DONE;
      cnt_d      = LD_GAP;
      ss_n_d     = 1'b1;
      rd_valid_d = 1'b0;
      tx_load    = 1'b1;
      tx_shift   = 1'b0;
      rx_shift   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      SS_n       <= 1'b1;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_frame_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      SS_n     <= ss_n_d;
      rd_valid <= rd_valid_d;
      if (rd_valid_d) rd_data    <= {rx_q[DATA_W-2:0], MISO};
      if (accept)     rd_frame_q <= (cmd_data[FRAME_W-1 -: 2] == CMD_RD_DATA);
    end
  end

endmodule
